// File: rtl/cabac_qp_pkg.sv
// rtl/cabac_qp_pkg.sv - shared constants and state encoding for the CABAC delta-QP pair scheduler
package cabac_qp_pkg;

    localparam int QP_W      = 6;
    localparam int PAIR_W    = 11;
    localparam int NUM_PAIRS = 8;
    localparam int INIT_QP   = 22;

    localparam logic [1:0] PAIR_CTX  = 2'b00;
    localparam logic [1:0] PAIR_NULL = 2'b01;
    localparam logic [1:0] PAIR_BYP  = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_EMIT = 2'd2,
        ST_DONE = 2'd3
    } sched_state_e;

endpackage

// File: rtl/cabac_pair_pick.sv
// rtl/cabac_pair_pick.sv - lowest-set-bit picker over the pending pair mask
module cabac_pair_pick #(
    parameter int N  = 8,
    parameter int IW = 3
) (
    input  logic [N-1:0]  mask_i,
    output logic [IW-1:0] idx_o,
    output logic          any_o
);

    // Scan downward so the lowest set bit is the last one written.
    always_comb begin
        idx_o = '0;
        any_o = |mask_i;
        for (int k = N - 1; k >= 0; k--) begin
            if (mask_i[k]) begin
                idx_o = IW'(k);
            end
        end
    end

endmodule

// File: rtl/cabac_qp_pair_sched.sv
// rtl/cabac_qp_pair_sched.sv - per-CU delta-QP sequencing: predictor state, pair capture and streaming
module cabac_qp_pair_sched #(
    parameter int QP_W      = cabac_qp_pkg::QP_W,
    parameter int PAIR_W    = cabac_qp_pkg::PAIR_W,
    parameter int NUM_PAIRS = cabac_qp_pkg::NUM_PAIRS,
    parameter int INIT_QP   = cabac_qp_pkg::INIT_QP
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          lcu_start_i,
    input  logic [QP_W-1:0]               slice_qp_i,
    input  logic                          cu_start_i,
    input  logic [QP_W-1:0]               cu_qp_i,
    input  logic                          cu_dqp_en_i,
    output logic [QP_W-1:0]               bin_curr_qp_o,
    output logic [QP_W-1:0]               bin_last_qp_o,
    input  logic [NUM_PAIRS*PAIR_W-1:0]   pairs_i,
    output logic [PAIR_W-1:0]             pair_o,
    output logic                          pair_valid_o,
    input  logic                          pair_ready_i,
    output logic                          busy_o,
    output logic                          done_o
);
    import cabac_qp_pkg::*;

    localparam int IDX_W = (NUM_PAIRS > 1) ? $clog2(NUM_PAIRS) : 1;

    sched_state_e                state_q, state_d;
    logic [QP_W-1:0]             last_qp_q, last_qp_d;
    logic [QP_W-1:0]             curr_q, curr_d;
    logic [QP_W-1:0]             last_q, last_d;
    logic                        en_q, en_d;
    logic [NUM_PAIRS*PAIR_W-1:0] pair_q, pair_d;
    logic [NUM_PAIRS-1:0]        mask_q, mask_d;
    logic                        valid_q, valid_d;
    logic                        done_q, done_d;

    logic [NUM_PAIRS-1:0]        load_mask;
    logic [NUM_PAIRS-1:0]        emit_mask;
    logic [IDX_W-1:0]            pick_idx;
    logic                        pick_any;

    always_comb begin
        load_mask = '0;
        for (int k = 0; k < NUM_PAIRS; k++) begin
            load_mask[k] = (pairs_i[k*PAIR_W + PAIR_W - 2 +: 2] != PAIR_NULL);
        end
    end

    cabac_pair_pick #(
        .N  (NUM_PAIRS),
        .IW (IDX_W)
    ) u_pick (
        .mask_i (mask_q),
        .idx_o  (pick_idx),
        .any_o  (pick_any)
    );

    assign emit_mask = mask_q & ~(NUM_PAIRS'(1) << pick_idx);

    always_comb begin
        state_d   = state_q;
        last_qp_d = last_qp_q;
        curr_d    = curr_q;
        last_d    = last_q;
        en_d      = en_q;
        pair_d    = pair_q;
        mask_d    = mask_q;
        case (state_q)
            ST_IDLE: begin
                if (lcu_start_i) begin
                    last_qp_d = slice_qp_i;
                end
                if (cu_start_i) begin
                    curr_d  = cu_qp_i;
                    last_d  = lcu_start_i ? slice_qp_i : last_qp_q;
                    en_d    = cu_dqp_en_i;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (en_q) begin
                    pair_d  = pairs_i;
                    mask_d  = load_mask;
                    state_d = (|load_mask) ? ST_EMIT : ST_DONE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            ST_EMIT: begin
                if (!pick_any) begin
                    state_d = ST_DONE;
                end else if (valid_q && pair_ready_i) begin
                    mask_d = emit_mask;
                    if (emit_mask == '0) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                if (en_q) begin
                    last_qp_d = curr_q;
                end
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        // Output flags are registered off the next state so they align with it.
        valid_d = (state_d == ST_EMIT);
        done_d  = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            last_qp_q <= QP_W'(INIT_QP);
            curr_q    <= '0;
            last_q    <= '0;
            en_q      <= 1'b0;
            pair_q    <= '0;
            mask_q    <= '0;
            valid_q   <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_qp_q <= last_qp_d;
            curr_q    <= curr_d;
            last_q    <= last_d;
            en_q      <= en_d;
            pair_q    <= pair_d;
            mask_q    <= mask_d;
            valid_q   <= valid_d;
            done_q    <= done_d;
        end
    end

    assign bin_curr_qp_o = curr_q;
    assign bin_last_qp_o = last_q;
    assign pair_valid_o  = valid_q;
    assign pair_o        = valid_q ? pair_q[pick_idx*PAIR_W +: PAIR_W] : '0;
    assign busy_o        = (state_q != ST_IDLE);
    assign done_o        = done_q;

endmodule

// File: tb/tb_cabac_qp_pair_sched.sv
// tb/tb_cabac_qp_pair_sched.sv - self-checking bench for cabac_qp_pair_sched
module tb_cabac_qp_pair_sched;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        lcu_start_i;
    logic [5:0]  slice_qp_i;
    logic        cu_start_i;
    logic [5:0]  cu_qp_i;
    logic        cu_dqp_en_i;
    logic [5:0]  bin_curr_qp_o;
    logic [5:0]  bin_last_qp_o;
    logic [87:0] pairs_i;
    logic [10:0] pair_o;
    logic        pair_valid_o;
    logic        pair_ready_i;
    logic        busy_o;
    logic        done_o;

    logic [87:0] loop_pairs;
    logic [87:0] rand_pairs;
    logic        use_loop;

    int n_checks = 0;
    int n_fail   = 0;
    int model_last_qp;

    always #5 clk = ~clk;

    cabac_qp_pair_sched dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .lcu_start_i   (lcu_start_i),
        .slice_qp_i    (slice_qp_i),
        .cu_start_i    (cu_start_i),
        .cu_qp_i       (cu_qp_i),
        .cu_dqp_en_i   (cu_dqp_en_i),
        .bin_curr_qp_o (bin_curr_qp_o),
        .bin_last_qp_o (bin_last_qp_o),
        .pairs_i       (pairs_i),
        .pair_o        (pair_o),
        .pair_valid_o  (pair_valid_o),
        .pair_ready_i  (pair_ready_i),
        .busy_o        (busy_o),
        .done_o        (done_o)
    );

    // Stand-in binarizer: zero delta gives one word, otherwise four words spread over nulls.
    function automatic logic [87:0] tb_binarize(input logic [5:0] c, input logic [5:0] l);
        logic [10:0] w [8];
        logic [87:0] r;
        int d;
        for (int i = 0; i < 8; i++) w[i] = 11'h200 | 11'(i);
        d = int'(c) - int'(l);
        if (d == 0) begin
            w[0] = 11'h063;
        end else begin
            w[0] = 11'h163;
            w[2] = 11'h122;
            w[3] = 11'h022;
            w[6] = (d < 0) ? 11'h421 : 11'h420;
        end
        for (int i = 0; i < 8; i++) r[i*11 +: 11] = w[i];
        return r;
    endfunction

    always_comb loop_pairs = tb_binarize(bin_curr_qp_o, bin_last_qp_o);
    always_comb pairs_i    = use_loop ? loop_pairs : rand_pairs;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // lcu_mode: 0 = none, 1 = same cycle as cu_start, 2 = one cycle before.
    task automatic run_cu(input int lcu_mode, input int slice, input int qp, input bit en,
                          input int stall, input logic [7:0][10:0] ew, input int n,
                          input int lat, input bit rnd_ready);
        int exp_last, cyc, idx, stalls, lows;
        bit rdy, fin;
        if (lcu_mode == 2) begin
            lcu_start_i = 1'b1;
            slice_qp_i  = 6'(slice);
            step();
            lcu_start_i   = 1'b0;
            model_last_qp = slice;
        end
        exp_last = (lcu_mode == 1) ? slice : model_last_qp;
        check("idle_busy", busy_o, 0);
        lcu_start_i = (lcu_mode == 1);
        slice_qp_i  = 6'(slice);
        cu_start_i  = 1'b1;
        cu_qp_i     = 6'(qp);
        cu_dqp_en_i = en;
        step();
        check("load_curr_qp", bin_curr_qp_o, 32'(qp));
        check("load_last_qp", bin_last_qp_o, 32'(exp_last));
        check("load_busy", busy_o, 1);
        check("load_valid", pair_valid_o, 0);
        // Starts while busy must be ignored.
        cu_start_i  = 1'b1;
        lcu_start_i = 1'b1;
        slice_qp_i  = 6'd7;
        cu_qp_i     = 6'd9;
        cu_dqp_en_i = ~en;
        step();
        cu_start_i  = 1'b0;
        lcu_start_i = 1'b0;
        if (!use_loop) rand_pairs = 88'({$urandom(), $urandom(), $urandom()});
        cyc = 2; idx = 0; stalls = 0; lows = 0; fin = 0;
        while (!fin && cyc < 80) begin
            if (idx < n) begin
                check("emit_valid", pair_valid_o, 1);
                check("emit_word", pair_o, 32'(ew[idx]));
                check("emit_no_done", done_o, 0);
                if (idx == 1 && stalls < stall) begin
                    rdy = 1'b0;
                    stalls++;
                end else if (rnd_ready) begin
                    rdy = ($urandom_range(0, 3) != 0);
                end else begin
                    rdy = 1'b1;
                end
                if (!rdy) lows++;
                pair_ready_i = rdy;
                if (rdy) idx++;
                step();
                cyc++;
            end else begin
                check("done_valid_low", pair_valid_o, 0);
                check("done_pulse", done_o, 1);
                check("done_latency", 32'(cyc), 32'((lat < 0) ? (2 + n + lows) : lat));
                check("done_curr_qp", bin_curr_qp_o, 32'(qp));
                check("done_last_qp", bin_last_qp_o, 32'(exp_last));
                fin = 1;
                pair_ready_i = 1'($urandom_range(0, 1));
                step();
                check("after_done_low", done_o, 0);
                check("after_busy_low", busy_o, 0);
            end
        end
        if (!fin) check("cu_timeout", 0, 1);
        pair_ready_i = 1'b1;
        if (lcu_mode == 1) model_last_qp = slice;
        if (en) model_last_qp = qp;
    endtask

    typedef struct {
        int          lcu_mode;
        int          slice;
        int          qp;
        bit          en;
        int          stall;
        int          n;
        logic [43:0] w;
        int          lat;
    } vec_t;

    localparam logic [43:0] W_UP   = {11'h420, 11'h022, 11'h122, 11'h163};
    localparam logic [43:0] W_DOWN = {11'h421, 11'h022, 11'h122, 11'h163};

    initial begin
        vec_t             vt [9];
        logic [7:0][10:0] ew;
        logic [10:0]      rw;
        logic [87:0]      rp;
        int               n, mode, slice, qp;
        bit               en;

        vt[0] = '{2, 30, 30, 1'b1, 0, 1, 44'h063, 3};
        vt[1] = '{1, 30, 32, 1'b1, 0, 4, W_UP,    6};
        vt[2] = '{0,  0, 32, 1'b1, 0, 1, 44'h063, 3};
        vt[3] = '{2, 30, 28, 1'b1, 0, 4, W_DOWN,  6};
        vt[4] = '{1, 30, 32, 1'b1, 3, 4, W_UP,    9};
        vt[5] = '{0,  0, 40, 1'b0, 0, 0, 44'h0,   2};
        vt[6] = '{0,  0, 32, 1'b1, 0, 1, 44'h063, 3};
        vt[7] = '{1, 10, 45, 1'b0, 0, 0, 44'h0,   2};
        vt[8] = '{0,  0, 10, 1'b1, 0, 1, 44'h063, 3};

        rst_n = 1'b0; lcu_start_i = 1'b0; slice_qp_i = '0; cu_start_i = 1'b0;
        cu_qp_i = '0; cu_dqp_en_i = 1'b0; pair_ready_i = 1'b1;
        use_loop = 1'b1; rand_pairs = '0;
        model_last_qp = 22;
        repeat (2) @(posedge clk);
        #1;
        check("rst_curr_qp", bin_curr_qp_o, 0);
        check("rst_last_qp", bin_last_qp_o, 0);
        check("rst_pair", pair_o, 0);
        check("rst_valid", pair_valid_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_done", done_o, 0);
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 9; i++) begin
            ew = '0;
            ew[3:0] = vt[i].w;
            run_cu(vt[i].lcu_mode, vt[i].slice, vt[i].qp, vt[i].en, vt[i].stall,
                   ew, vt[i].n, vt[i].lat, 1'b0);
        end

        // Reset in the middle of the stream after two handshakes.
        lcu_start_i = 1'b1; slice_qp_i = 6'd30; cu_start_i = 1'b1;
        cu_qp_i = 6'd32; cu_dqp_en_i = 1'b1; pair_ready_i = 1'b1;
        step();
        lcu_start_i = 1'b0; cu_start_i = 1'b0;
        repeat (3) step();
        check("pre_rst_word", pair_o, 32'h022);
        #2 rst_n = 1'b0;
        #1;
        check("arst_valid", pair_valid_o, 0);
        check("arst_pair", pair_o, 0);
        check("arst_busy", busy_o, 0);
        check("arst_curr_qp", bin_curr_qp_o, 0);
        check("arst_last_qp", bin_last_qp_o, 0);
        step();
        check("arst_no_done", done_o, 0);
        rst_n = 1'b1;
        step();
        check("post_rst_no_done", done_o, 0);
        model_last_qp = 22;
        ew = '0;
        ew[0] = 11'h063;
        run_cu(0, 0, 22, 1'b1, 0, ew, 1, 3, 1'b0);

        // All-empty capture goes straight to DONE.
        use_loop = 1'b0;
        for (int k = 0; k < 8; k++) rand_pairs[k*11 +: 11] = 11'h200 | 11'(k * 37);
        run_cu(0, 0, 17, 1'b1, 0, '0, 0, 2, 1'b0);

        for (int r = 0; r < 40; r++) begin
            for (int k = 0; k < 8; k++) begin
                case ($urandom_range(0, 3))
                    0:       rw = {2'b00, 9'($urandom())};
                    1:       rw = {2'b10, 9'($urandom())};
                    default: rw = {2'b01, 9'($urandom())};
                endcase
                rp[k*11 +: 11] = rw;
            end
            mode  = $urandom_range(0, 3);
            mode  = (mode == 3) ? 0 : mode;
            slice = $urandom_range(0, 51);
            qp    = $urandom_range(0, 51);
            en    = ($urandom_range(0, 3) != 0);
            ew = '0;
            n  = 0;
            for (int k = 0; k < 8; k++) begin
                if (en && rp[k*11 + 9 +: 2] != 2'b01) begin
                    ew[n] = rp[k*11 +: 11];
                    n++;
                end
            end
            rand_pairs = rp;
            run_cu(mode, slice, qp, en, 0, ew, n, -1, 1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
